// File: rtl/contadores_sincronos.sv
// contadores_sincronos: free-running up, down and up/down bounce counters sharing clk and rst.
module contador_sincrono_crescente #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  output logic [WIDTH-1:0] q
);
  always_ff @(posedge clk) q <= rst ? '0 : q + 1'b1;
endmodule

module contador_sincrono_decrescente #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  output logic [WIDTH-1:0] q
);
  always_ff @(posedge clk) q <= rst ? '1 : q - 1'b1;
endmodule

module contador_sincrono #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  output logic [WIDTH-1:0] count,
  output logic             dir
);
  localparam logic [WIDTH-1:0] MAX = '1;
  // Turn around at both ends so MAX and 0 are each held for a single cycle.
  always_ff @(posedge clk)
    if (rst) begin
      count <= '0;
      dir   <= 1'b1;
    end else if (dir) begin
      count <= (count == MAX) ? MAX - 1'b1 : count + 1'b1;
      dir   <= count != MAX;
    end else begin
      count <= (count == '0) ? {{(WIDTH-1){1'b0}}, 1'b1} : count - 1'b1;
      dir   <= count == '0;
    end
endmodule

module contadores_sincronos #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  output logic [WIDTH-1:0] q_crescente,
  output logic [WIDTH-1:0] q_decrescente,
  output logic [WIDTH-1:0] count,
  output logic             dir_misto
);
  contador_sincrono_crescente #(.WIDTH(WIDTH)) u_crescente (
    .clk (clk),
    .rst (rst),
    .q   (q_crescente)
  );
  contador_sincrono_decrescente #(.WIDTH(WIDTH)) u_decrescente (
    .clk (clk),
    .rst (rst),
    .q   (q_decrescente)
  );
  contador_sincrono #(.WIDTH(WIDTH)) u_misto (
    .clk   (clk),
    .rst   (rst),
    .count (count),
    .dir   (dir_misto)
  );
endmodule

// File: tb/tb_contadores_sincronos.sv
// tb_contadores_sincronos: directed and randomized checks against a step-count reference model.
module tb_contadores_sincronos;
  localparam int W = 4;
  localparam int M = (1 << W) - 1;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [W-1:0] q_crescente, q_decrescente, count;
  logic dir_misto;
  int n_cmp = 0;
  int n_bad = 0;
  int n = 0;
  contadores_sincronos #(.WIDTH(W)) dut (
    .clk           (clk),
    .rst           (rst),
    .q_crescente   (q_crescente),
    .q_decrescente (q_decrescente),
    .count         (count),
    .dir_misto     (dir_misto)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_bad++;
      $error("FAIL %s step=%0d got=%0d want=%0d", tag, n, got, exp);
    end
  endtask
  // Expected values follow from the number of counting edges since the last reset.
  task automatic step(input logic r);
    int p;
    rst = r;
    @(posedge clk);
    #1;
    n = r ? 0 : n + 1;
    p = n % (2 * M);
    chk("up", {28'd0, q_crescente}, n % (M + 1));
    chk("down", {28'd0, q_decrescente}, M - (n % (M + 1)));
    chk("sum", {27'd0, q_crescente} + {27'd0, q_decrescente}, M);
    chk("mixed", {28'd0, count}, (p <= M) ? p : 2 * M - p);
    chk("dir", {31'd0, dir_misto}, (n == 0 || (p >= 1 && p <= M)) ? 1 : 0);
  endtask
  initial begin
    step(1'b1);
    step(1'b0);
    repeat (14) step(1'b0);
    step(1'b0);
    repeat (14) step(1'b0);
    step(1'b0);
    step(1'b1);
    repeat (19) step(1'b0);
    step(1'b1);
    step(1'b0);
    repeat (5) step(1'b1);
    repeat (250) step($urandom_range(0, 39) == 0);
    repeat (60) step(1'b0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/contadores_sincronos.md
CONTADORES_SINCRONOS -- requirements
Module: contadores_sincronos

Interface
REQ-001 The block SHALL have one parameter, WIDTH, default 4, which sets the counter width in bits for all three counters.
REQ-002 Port clk, input, 1 bit, SHALL be the single clock; all state updates on its rising edge.
REQ-003 Port rst, input, 1 bit, SHALL be the reset; it is synchronous and active-high.
REQ-004 Port q_crescente, output, WIDTH bits, SHALL carry the up-counter value.
REQ-005 Port q_decrescente, output, WIDTH bits, SHALL carry the down-counter value.
REQ-006 Port count, output, WIDTH bits, SHALL carry the mixed (up/down bounce) counter value.
REQ-007 Port dir_misto, output, 1 bit, SHALL carry the mixed counter direction (1 = counting up, 0 = counting down).
REQ-008 The block SHALL be built from three separately instantiable submodules sharing clk and rst:
- contador_sincrono_crescente (clk, rst, q)
- contador_sincrono_decrescente (clk, rst, q)
- contador_sincrono (clk, rst, count)

Function
REQ-009 All outputs SHALL be registered, with no combinational path from rst to any output.
REQ-010 Up counter SHALL take q <= q + 1 on each rising edge when rst=0.
REQ-011 Up counter SHALL wrap from 2^WIDTH-1 to 0 (15 -> 0 for WIDTH=4).
REQ-012 Down counter SHALL take q <= q - 1 on each rising edge when rst=0.
REQ-013 Down counter SHALL wrap from 0 to 2^WIDTH-1 (0 -> 15).
REQ-014 Mixed counter SHALL keep an internal direction register dir (exported as dir_misto).
REQ-015 Mixed counter, dir=1 and count<MAX (MAX=2^WIDTH-1): count <= count+1.
REQ-016 Mixed counter, dir=1 and count==MAX: count <= MAX-1 and dir <= 0, so MAX is held for exactly one cycle.
REQ-017 Mixed counter, dir=0 and count>0: count <= count-1.
REQ-018 Mixed counter, dir=0 and count==0: count <= 1 and dir <= 1.
REQ-019 Mixed counter sequence SHALL be 0,1,...,15,14,...,1,0,1,..., with a period of 2*MAX = 30 cycles.
REQ-020 The mixed counter SHALL never wrap modulo 2^WIDTH.
REQ-021 All three counters SHALL have latency of one clock per step; each output changes exactly once per rising edge while rst=0.
REQ-022 The counters SHALL be free-running, with no enable and no load.

Reset
REQ-023 When rst=1 at a rising edge, the registers SHALL take:
- q_crescente = 0
- q_decrescente = 2^WIDTH-1 (15)
- count = 0
- dir_misto = 1
REQ-024 Reset SHALL take priority over counting at every edge, including mid-sequence and at wrap/turn-around points.
REQ-025 Holding rst=1 for multiple edges SHALL keep the reset values.
REQ-026 The first count step SHALL occur on the first rising edge with rst=0.
REQ-027 Output values before the first reset edge are undefined, and the bench SHALL NOT check them.

Verification
REQ-028 Initial reset: rst=1 for one edge, then released, then one edge -> (q_crescente, q_decrescente, count) = (0,15,0) then (1,14,1), dir_misto=1.
REQ-029 Wrap/turn-around: 15 edges after release -> (15,0,15); 16 edges -> (0,15,14) with dir_misto=0.
REQ-030 Full bounce: 30 edges after release -> (14,1,0) with dir_misto=0; 31 edges -> (15,0,1) with dir_misto=1.
REQ-031 Mid-operation reset: 19 edges after release -> (3,12,11); then rst=1 for one edge -> (0,15,0) with dir_misto=1; after release, the next edge -> (1,14,1).
REQ-032 Long run: 200+ free-running edges; each cycle, q_crescente + q_decrescente == 15, and count matches a reference bounce model.
REQ-033 Sustained reset: rst=1 for 5 consecutive edges -> outputs stay at (0,15,0) with dir_misto=1 throughout.
